// File: rtl/spi_target_regfile.sv
// spi_target_regfile
//   SPI target (slave) with an internal register file, clocked directly by
//   sclk. A frame is ADDR_W address bits followed by one word (or, with
//   BURST_EN, a run of words at auto-incrementing addresses), MSB-first.
//   The direction is taken from rd_wr on the first frame edge only.
//
// Ports
//   sclk       serial clock, all state changes on posedge
//   rst_n      asynchronous active-low reset (clears register file too)
//   ssel       active-low target select
//   rd_wr      direction, 1 = read, 0 = write (first frame edge only)
//   mosi       serial data in, MSB-first
//   miso       serial data out, MSB-first, 0 outside RDATA
//   miso_oe    high while selected and in RDATA
//   wr_strobe  one-cycle pulse after a register write commits
//   wr_addr    address of the last committed write
//   wr_data    data of the last committed write
//   frame_err  sticky: last frame ended mid address/word
//   busy       state != IDLE
module spi_target_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter bit BURST_EN = 1'b1
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              ssel,
  input  logic              rd_wr,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int MAXW  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W = $clog2(MAXW);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               dir;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  data_sr;
  logic [DATA_W-1:0]  out_sr;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               addr_last;
  logic               word_last;
  logic [ADDR_W-1:0]  addr_shift;
  logic [ADDR_W-1:0]  addr_inc;
  logic [DATA_W-1:0]  data_shift;
  logic               partial;

  assign addr_last  = (cnt == CNT_W'(ADDR_W - 1));
  assign word_last  = (cnt == CNT_W'(DATA_W - 1));
  assign addr_shift = {addr[ADDR_W-2:0], mosi};
  assign data_shift = {data_sr[DATA_W-2:0], mosi};
  assign addr_inc   = addr + ADDR_W'(1);
  // A frame ending now would leave a field half-shifted.
  assign partial    = (state == ADDR) ||
                      (((state == WDATA) || (state == RDATA)) && (cnt != '0));

  // State register
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (ssel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = ADDR;
        ADDR:  if (addr_last) state_nxt = dir ? RDATA : WDATA;
        WDATA,
        RDATA: if (word_last && !BURST_EN) state_nxt = DONE;
        DONE:  state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    miso    = 1'b0;
    miso_oe = 1'b0;
    busy    = (state != IDLE);
    if ((state == RDATA) && !ssel) begin
      miso_oe = 1'b1;
      miso    = out_sr[DATA_W-1];
    end
  end

  // Datapath: shift registers, counter, register file and write reporting
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dir       <= 1'b0;
      addr      <= '0;
      data_sr   <= '0;
      out_sr    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (ssel) begin
        cnt <= '0;
        if (partial) frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            dir       <= rd_wr;
            addr      <= addr_shift;
            cnt       <= CNT_W'(1);
            frame_err <= 1'b0;
          end
          ADDR: begin
            addr <= addr_shift;
            if (addr_last) begin
              cnt <= '0;
              // Preload so the MSB is on miso for the master's next edge.
              if (dir) out_sr <= mem[addr_shift];
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          WDATA: begin
            data_sr <= data_shift;
            if (word_last) begin
              mem[addr] <= data_shift;
              wr_addr   <= addr;
              wr_data   <= data_shift;
              wr_strobe <= 1'b1;
              cnt       <= '0;
              if (BURST_EN) addr <= addr_inc;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RDATA: begin
            if (word_last) begin
              cnt <= '0;
              if (BURST_EN) begin
                addr   <= addr_inc;
                out_sr <= mem[addr_inc];
              end else begin
                out_sr <= '0;
              end
            end else begin
              out_sr <= {out_sr[DATA_W-2:0], 1'b0};
              cnt    <= cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
